// File: rtl/control_unit_if.sv
// Bus bundle between the tiny16 sequencer and its memory / register-file
// datapath. The master modport is the sequencer side; the slave modport is
// the memory + datapath side. Building with SINGLE_STEP_EN adds the
// step/paused pair.
interface control_unit_if;
  logic [15:0] mem_rdata;
  logic        mem_ready;
  logic        mem_req;
  logic        mem_we;
  logic [1:0]  addr_sel;
  logic [2:0]  src_sel;
  logic [2:0]  dst_sel;
  logic        reg_in_en;
  logic        reg_out_en;
  logic        pc_inc;
  logic [1:0]  wb_sel;
  logic [2:0]  alu_op;
  logic [15:0] ir;
  logic        halted;
  logic        illegal;
  logic        bus_err;
`ifdef SINGLE_STEP_EN
  logic        step;
  logic        paused;
`endif

  modport master (
`ifdef SINGLE_STEP_EN
    input  step,
    output paused,
`endif
    input  mem_rdata, mem_ready,
    output mem_req, mem_we, addr_sel, src_sel, dst_sel, reg_in_en,
           reg_out_en, pc_inc, wb_sel, alu_op, ir, halted, illegal, bus_err
  );

  modport slave (
`ifdef SINGLE_STEP_EN
    output step,
    input  paused,
`endif
    output mem_rdata, mem_ready,
    input  mem_req, mem_we, addr_sel, src_sel, dst_sel, reg_in_en,
           reg_out_en, pc_inc, wb_sel, alu_op, ir, halted, illegal, bus_err
  );
endinterface

// File: rtl/control_unit.sv
// tiny16 multicycle sequencer: fetch / decode / execute one 16-bit
// instruction at a time, driving register-file controls, write-back mux,
// ALU op and the memory request handshake.
// Optional build macro: SINGLE_STEP_EN (adds step/paused and a PAUSE state
// entered after every completed instruction and out of reset).
module control_unit #(
  parameter int unsigned TIMEOUT  = 255,
  parameter logic [3:0]  HALT_OPC = 4'hF
) (
  input  logic           clk,
  input  logic           rst,
  control_unit_if.master bus
);

  localparam int CW = $clog2(TIMEOUT + 1);

  localparam logic [3:0] OPC_NOP = 4'h0;
  localparam logic [3:0] OPC_MOV = 4'h1;
  localparam logic [3:0] OPC_LDI = 4'h2;
  localparam logic [3:0] OPC_LD  = 4'h3;
  localparam logic [3:0] OPC_ST  = 4'h4;
  localparam logic [3:0] OPC_ALU = 4'h5;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_IMM,
    S_MEM,
    S_HALT
`ifdef SINGLE_STEP_EN
    , S_PAUSE
`endif
  } state_t;

  // Where a finished instruction goes, and where reset leaves the sequencer.
`ifdef SINGLE_STEP_EN
  localparam state_t DONE_ST  = S_PAUSE;
  localparam state_t RESET_ST = S_PAUSE;
`else
  localparam state_t DONE_ST  = S_FETCH;
  localparam state_t RESET_ST = S_FETCH;
`endif

  state_t          state_reg, state_next;
  logic [15:0]     ir_reg, ir_next;
  logic [CW-1:0]   cnt_reg, cnt_next;
  logic            illegal_reg, illegal_next;
  logic            bus_err_reg, bus_err_next;

  // Registered decodes of the state being entered.
  logic            mem_req_reg;
  logic            mem_we_reg;
  logic            reg_out_en_reg;
  logic [1:0]      addr_sel_reg;
  logic [1:0]      wb_sel_reg;
  logic            halted_reg;
  logic            exec_we_reg;   // register write that needs no memory (EXEC)
  logic            ready_we_reg;  // register write qualified by mem_ready (IMM, LD)
  logic            ready_pc_reg;  // PC increment qualified by mem_ready (FETCH, IMM)
`ifdef SINGLE_STEP_EN
  logic            paused_reg;
`endif

  logic [3:0]      opcode;
  logic            xfer;
  logic            stall;
  logic            expire;

  assign opcode = ir_reg[15:12];

  // Handshake qualifiers; mem_ready is only meaningful while a request is up,
  // and a ready in the expiry cycle still completes the transfer.
  assign xfer   = mem_req_reg & bus.mem_ready;
  assign stall  = mem_req_reg & ~bus.mem_ready;
  assign expire = stall & (cnt_reg == CW'(TIMEOUT - 1));

  // Next-state, instruction register and sticky-flag logic.
  always_comb begin
    state_next   = state_reg;
    ir_next      = ir_reg;
    illegal_next = illegal_reg;
    bus_err_next = bus_err_reg;
    case (state_reg)
      S_FETCH: begin
        // The first cycle after reset has no request up yet; stay here
        // until the request registers, then wait for mem_ready.
        if (xfer) begin
          ir_next    = bus.mem_rdata;
          state_next = S_DECODE;
        end else if (expire) begin
          bus_err_next = 1'b1;
          state_next   = S_HALT;
        end
      end
      S_DECODE: begin
        if (opcode == HALT_OPC) begin
          state_next = S_HALT;
        end else begin
          case (opcode)
            OPC_NOP:          state_next = DONE_ST;
            OPC_MOV, OPC_ALU: state_next = S_EXEC;
            OPC_LDI:          state_next = S_IMM;
            OPC_LD, OPC_ST:   state_next = S_MEM;
            default: begin
              illegal_next = 1'b1;
              state_next   = DONE_ST;
            end
          endcase
        end
      end
      S_EXEC: state_next = DONE_ST;
      S_IMM, S_MEM: begin
        if (xfer) begin
          state_next = DONE_ST;
        end else if (expire) begin
          bus_err_next = 1'b1;
          state_next   = S_HALT;
        end
      end
      S_HALT: state_next = S_HALT;
`ifdef SINGLE_STEP_EN
      S_PAUSE: begin
        if (bus.step) state_next = S_FETCH;
      end
`endif
      default: state_next = S_HALT;
    endcase
  end

  // Wait-cycle counter: cleared whenever the state changes, counts stalled
  // request cycles while it does not.
  always_comb begin
    cnt_next = cnt_reg;
    if (state_next != state_reg) begin
      cnt_next = '0;
    end else if (stall) begin
      cnt_next = cnt_reg + 1'b1;
    end
  end

  // State register plus registered output decodes of the state being entered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= RESET_ST;
      ir_reg         <= '0;
      cnt_reg        <= '0;
      illegal_reg    <= 1'b0;
      bus_err_reg    <= 1'b0;
      mem_req_reg    <= 1'b0;
      mem_we_reg     <= 1'b0;
      reg_out_en_reg <= 1'b0;
      addr_sel_reg   <= 2'd0;
      wb_sel_reg     <= 2'd0;
      halted_reg     <= 1'b0;
      exec_we_reg    <= 1'b0;
      ready_we_reg   <= 1'b0;
      ready_pc_reg   <= 1'b0;
`ifdef SINGLE_STEP_EN
      paused_reg     <= 1'b1;
`endif
    end else begin
      state_reg      <= state_next;
      ir_reg         <= ir_next;
      cnt_reg        <= cnt_next;
      illegal_reg    <= illegal_next;
      bus_err_reg    <= bus_err_next;
      // ir_reg is already valid whenever EXEC or MEM is being entered.
      mem_req_reg    <= (state_next == S_FETCH) || (state_next == S_IMM) ||
                        (state_next == S_MEM);
      mem_we_reg     <= (state_next == S_MEM) && (opcode == OPC_ST);
      reg_out_en_reg <= (state_next == S_FETCH) || (state_next == S_IMM);
      addr_sel_reg   <= (state_next != S_MEM)  ? 2'd0 :
                        (opcode == OPC_ST)     ? 2'd2 : 2'd1;
      wb_sel_reg     <= (state_next != S_EXEC) ? 2'd0 :
                        (opcode == OPC_MOV)    ? 2'd2 : 2'd1;
      halted_reg     <= (state_next == S_HALT);
      exec_we_reg    <= (state_next == S_EXEC);
      ready_we_reg   <= (state_next == S_IMM) ||
                        ((state_next == S_MEM) && (opcode == OPC_LD));
      ready_pc_reg   <= (state_next == S_FETCH) || (state_next == S_IMM);
`ifdef SINGLE_STEP_EN
      paused_reg     <= (state_next == S_PAUSE);
`endif
    end
  end

  // Strobes fire only in the cycle the handshake completes (or in EXEC).
  assign bus.pc_inc     = ready_pc_reg & xfer;
  assign bus.reg_in_en  = exec_we_reg | (ready_we_reg & xfer);

  assign bus.mem_req    = mem_req_reg;
  assign bus.mem_we     = mem_we_reg;
  assign bus.addr_sel   = addr_sel_reg;
  assign bus.reg_out_en = reg_out_en_reg;
  assign bus.wb_sel     = wb_sel_reg;
  assign bus.src_sel    = ir_reg[8:6];
  assign bus.dst_sel    = ir_reg[11:9];
  assign bus.alu_op     = ir_reg[2:0];
  assign bus.ir         = ir_reg;
  assign bus.halted     = halted_reg;
  assign bus.illegal    = illegal_reg;
  assign bus.bus_err    = bus_err_reg;
`ifdef SINGLE_STEP_EN
  assign bus.paused     = paused_reg;
`endif

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit. The bench plays the memory; each
// instruction's expected cycle count, strobes and selects come from the
// instruction-level rules (cycles per opcode plus wait states).
module tb_control_unit;
  localparam int unsigned TIMEOUT = 4;

  logic clk = 1'b0;
  logic rst;
  int   tests_run    = 0;
  int   tests_failed = 0;
  bit   model_illegal;

  control_unit_if bus();

  control_unit #(.TIMEOUT(TIMEOUT), .HALT_OPC(4'hF)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.mem_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_illegal = 1'b0;
    @(posedge clk);
  endtask

  // Play memory for one instruction; w0/w1 are wait cycles on the fetch and
  // on the second transfer (immediate, load or store).
  task automatic run_instr(input logic [15:0] instr, input logic [15:0] data,
                           input int w0, input int w1, input string tag);
    logic [3:0] opc;
    int exp_cycles, exp_pc, req_idx, wait_cnt, n_pc, n_we, we_cycle, req2_cycles;
    bit exp_second, exp_write, start_bad, strobe_bad, second_bad, exp_halt;
    logic ready, exp_we, exp_oe;
    logic [1:0] exp_wb, exp_addr, we_wb;
    logic [2:0] we_dst, we_src, we_alu;
    opc        = instr[15:12];
    exp_halt   = (opc == 4'hF);
    if (opc > 4'h5 && !exp_halt) model_illegal = 1'b1;
    exp_second = (opc inside {4'h2, 4'h3, 4'h4});
    exp_write  = (opc inside {4'h1, 4'h2, 4'h3, 4'h5});
    exp_pc     = (opc == 4'h2) ? 2 : 1;
    exp_cycles = 1 + w0 + 1 + ((opc == 4'h1 || opc == 4'h5) ? 1 : 0) +
                 (exp_second ? 1 + w1 : 0);
    exp_wb     = (opc == 4'h1) ? 2'd2 : (opc == 4'h5) ? 2'd1 : 2'd0;
    exp_addr   = (opc == 4'h3) ? 2'd1 : (opc == 4'h4) ? 2'd2 : 2'd0;
    exp_we     = (opc == 4'h4);
    exp_oe     = (opc == 4'h2);
    req_idx = 0; wait_cnt = 0; n_pc = 0; n_we = 0; we_cycle = -1; req2_cycles = 0;
    start_bad = 0; strobe_bad = 0; second_bad = 0;
    we_wb = 2'd0; we_dst = 3'd0; we_src = 3'd0; we_alu = 3'd0;
    for (int c = 0; c < exp_cycles; c++) begin
      @(negedge clk);
      if (bus.mem_req === 1'b1) begin
        ready = (wait_cnt == ((req_idx == 0) ? w0 : w1));
        bus.mem_rdata = (req_idx == 0) ? instr : data;
      end else begin
        ready = 1'($urandom_range(0, 1));
        bus.mem_rdata = 16'($urandom);
      end
      bus.mem_ready = ready;
      #1;
      if (c == 0 && !(bus.mem_req === 1'b1 && bus.addr_sel === 2'd0 &&
                      bus.reg_out_en === 1'b1 && bus.mem_we === 1'b0))
        start_bad = 1;
      if (bus.mem_req === 1'b1 && req_idx >= 1) begin
        req2_cycles++;
        if (bus.addr_sel !== exp_addr || bus.mem_we !== exp_we || bus.reg_out_en !== exp_oe)
          second_bad = 1;
      end
      if (bus.pc_inc !== 1'b0) begin
        n_pc++;
        if (!(bus.mem_req === 1'b1 && ready === 1'b1)) strobe_bad = 1;
      end
      if (bus.reg_in_en !== 1'b0) begin
        n_we++;
        we_cycle = c;
        we_dst = bus.dst_sel; we_src = bus.src_sel; we_wb = bus.wb_sel; we_alu = bus.alu_op;
      end
      if (bus.mem_req === 1'b1) begin
        if (ready) begin req_idx++; wait_cnt = 0; end
        else wait_cnt++;
      end
    end
    @(posedge clk);
    #1;
    $display("[TB] %s instr=%h w0=%0d w1=%0d cycles=%0d pc_inc=%0d wr=%0d",
             tag, instr, w0, w1, exp_cycles, n_pc, n_we);
    tests_run++;
    if (start_bad) begin
      tests_failed++; $display("FAIL %s fetch_start: fetch bus shape wrong in first cycle", tag);
    end
    tests_run++;
    if (n_pc != exp_pc) begin
      tests_failed++; $display("FAIL %s pc_inc_count: got %0d expected %0d", tag, n_pc, exp_pc);
    end
    tests_run++;
    if (strobe_bad) begin
      tests_failed++; $display("FAIL %s pc_inc_timing: pc_inc outside a mem_ready cycle", tag);
    end
    tests_run++;
    if (n_we != (exp_write ? 1 : 0)) begin
      tests_failed++; $display("FAIL %s reg_in_en_count: got %0d expected %0d", tag, n_we, exp_write ? 1 : 0);
    end
    if (exp_write) begin
      tests_run++;
      if (we_cycle != exp_cycles - 1 || we_dst !== instr[11:9] || we_wb !== exp_wb) begin
        tests_failed++;
        $display("FAIL %s write: cycle=%0d dst=%0d wb=%0d expected cycle=%0d dst=%0d wb=%0d",
                 tag, we_cycle, we_dst, we_wb, exp_cycles - 1, instr[11:9], exp_wb);
      end
      if (opc == 4'h1 || opc == 4'h5) begin
        tests_run++;
        if (we_src !== instr[8:6] || (opc == 4'h5 && we_alu !== instr[2:0])) begin
          tests_failed++;
          $display("FAIL %s src_alu: src=%0d alu=%0d expected src=%0d alu=%0d",
                   tag, we_src, we_alu, instr[8:6], instr[2:0]);
        end
      end
    end
    tests_run++;
    if (req2_cycles != (exp_second ? w1 + 1 : 0)) begin
      tests_failed++;
      $display("FAIL %s second_req_len: got %0d expected %0d", tag, req2_cycles, exp_second ? w1 + 1 : 0);
    end
    if (exp_second) begin
      tests_run++;
      if (second_bad) begin
        tests_failed++;
        $display("FAIL %s second_req_shape: expected addr_sel=%0d mem_we=%0d reg_out_en=%0d",
                 tag, exp_addr, exp_we, exp_oe);
      end
    end
    tests_run++;
    if (bus.ir !== instr) begin
      tests_failed++; $display("FAIL %s ir: got %h expected %h", tag, bus.ir, instr);
    end
    tests_run++;
    if (bus.illegal !== model_illegal) begin
      tests_failed++; $display("FAIL %s illegal: got %b expected %b", tag, bus.illegal, model_illegal);
    end
    tests_run++;
    if (bus.halted !== exp_halt || bus.bus_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s status: halted=%b bus_err=%b expected halted=%b bus_err=0",
               tag, bus.halted, bus.bus_err, exp_halt);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = 16'h0;
`ifdef SINGLE_STEP_EN
    bus.step = 1'b0;
`endif
    model_illegal = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    tests_run++;
    if (bus.mem_req !== 1'b0 || bus.mem_we !== 1'b0 || bus.addr_sel !== 2'd0 || bus.reg_out_en !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_mem: req=%b we=%b addr=%0d oe=%b expected all 0",
               bus.mem_req, bus.mem_we, bus.addr_sel, bus.reg_out_en);
    end
    tests_run++;
    if (bus.pc_inc !== 1'b0 || bus.reg_in_en !== 1'b0) begin
      tests_failed++; $display("FAIL reset_strobes: pc_inc=%b reg_in_en=%b expected 0", bus.pc_inc, bus.reg_in_en);
    end
    tests_run++;
    if (bus.ir !== 16'h0 || bus.wb_sel !== 2'd0 || bus.alu_op !== 3'd0) begin
      tests_failed++;
      $display("FAIL reset_ir: ir=%h wb=%0d alu=%0d expected 0", bus.ir, bus.wb_sel, bus.alu_op);
    end
    tests_run++;
    if (bus.halted !== 1'b0 || bus.illegal !== 1'b0 || bus.bus_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_status: halted=%b illegal=%b bus_err=%b expected 0",
               bus.halted, bus.illegal, bus.bus_err);
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
    tests_run++;
`ifdef SINGLE_STEP_EN
    if (bus.paused !== 1'b1 || bus.mem_req !== 1'b0) begin
      tests_failed++; $display("FAIL reset_pause: paused=%b mem_req=%b expected 1/0", bus.paused, bus.mem_req);
    end
`else
    if (bus.mem_req !== 1'b1) begin
      tests_failed++; $display("FAIL reset_fetch: mem_req=%b expected 1", bus.mem_req);
    end
`endif
  endtask

  task automatic test_mov();
    run_instr(16'h1280, 16'h0, 0, 0, "mov");
  endtask

  task automatic test_ldi();
    run_instr(16'h2600, 16'd20, 0, 0, "ldi");
  endtask

  task automatic test_store();
    run_instr(16'h4440, 16'h0, 0, 3, "st");
  endtask

  task automatic test_random();
    logic [15:0] instr;
    for (int i = 0; i < 60; i++) begin
      instr = {4'($urandom_range(0, 14)), 12'($urandom)};
      run_instr(instr, 16'($urandom), $urandom_range(0, 3), $urandom_range(0, 3), "rand");
    end
  endtask

  task automatic test_illegal();
    do_reset();
    run_instr(16'h7abc, 16'h0, 1, 0, "illegal");
    run_instr(16'h0000, 16'h0, 0, 0, "nop_after_illegal");
  endtask

  task automatic test_halt();
    bit bad;
    run_instr(16'hF000, 16'h0, 0, 0, "halt");
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      bus.mem_ready = 1'($urandom_range(0, 1));
      #1;
      if (bus.mem_req !== 1'b0 || bus.pc_inc !== 1'b0 || bus.reg_in_en !== 1'b0 || bus.halted !== 1'b1)
        bad = 1;
    end
    tests_run++;
    if (bad) begin
      tests_failed++; $display("FAIL halt_hold: activity seen after HALT (req=%b halted=%b)", bus.mem_req, bus.halted);
    end
  endtask

  task automatic test_timeout();
    int n_req;
    bit strobe_seen;
    do_reset();
    n_req = 0; strobe_seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bus.mem_ready = 1'b0;
      #1;
      if (bus.mem_req === 1'b1) n_req++;
      if (bus.pc_inc !== 1'b0 || bus.reg_in_en !== 1'b0) strobe_seen = 1;
    end
    $display("[TB] timeout req_cycles=%0d bus_err=%b halted=%b", n_req, bus.bus_err, bus.halted);
    tests_run++;
    if (n_req != int'(TIMEOUT)) begin
      tests_failed++; $display("FAIL timeout_len: mem_req cycles got %0d expected %0d", n_req, TIMEOUT);
    end
    tests_run++;
    if (bus.bus_err !== 1'b1 || bus.halted !== 1'b1 || strobe_seen) begin
      tests_failed++;
      $display("FAIL timeout_status: bus_err=%b halted=%b strobe=%b expected 1/1/0",
               bus.bus_err, bus.halted, strobe_seen);
    end
  endtask

  task automatic test_reset_mid_wait();
    do_reset();
    run_instr(16'h7001, 16'h0, 0, 0, "pre_reset_illegal");
    bus.mem_ready = 1'b0;
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    tests_run++;
    if (bus.mem_req !== 1'b0 || bus.reg_out_en !== 1'b0 || bus.addr_sel !== 2'd0 || bus.pc_inc !== 1'b0) begin
      tests_failed++;
      $display("FAIL midreset_mem: req=%b oe=%b addr=%0d pc_inc=%b expected 0",
               bus.mem_req, bus.reg_out_en, bus.addr_sel, bus.pc_inc);
    end
    tests_run++;
    if (bus.illegal !== 1'b0 || bus.ir !== 16'h0 || bus.halted !== 1'b0 || bus.bus_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL midreset_status: illegal=%b ir=%h halted=%b bus_err=%b expected 0",
               bus.illegal, bus.ir, bus.halted, bus.bus_err);
    end
    do_reset();
  endtask

`ifdef SINGLE_STEP_EN
  task automatic test_single_step();
    bit bad;
    @(negedge clk);
    bus.step = 1'b1;
    @(posedge clk);
    #1;
    bus.step = 1'b0;
    run_instr(16'h1280, 16'h0, 0, 0, "step_mov");
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      if (bus.paused !== 1'b1 || bus.mem_req !== 1'b0) bad = 1;
    end
    tests_run++;
    if (bad) begin
      tests_failed++; $display("FAIL step_pause: paused=%b mem_req=%b expected 1/0", bus.paused, bus.mem_req);
    end
  endtask
`endif

  initial begin
    test_reset();
`ifdef SINGLE_STEP_EN
    test_single_step();
`else
    test_mov();
    test_ldi();
    test_store();
    test_random();
    test_illegal();
    test_halt();
    test_timeout();
    test_reset_mid_wait();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/control_unit.md
Name: control_unit

Overview:
Multicycle sequencer for the tiny16 core. It drives the 8-entry register file's control inputs (src_sel, dst_sel, in_en, out_en, pc_inc), the register write-data mux, the ALU operation and the memory handshake. It fetches, decodes and executes one 16-bit instruction at a time and sits between the memory interface and the register file/ALU datapath.

Parameters:
TIMEOUT, 255, max cycles to wait for mem_ready before aborting to HALT with bus_err; counter width is clog2(TIMEOUT+1)
HALT_OPC, 4'hF, opcode that halts the sequencer

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
mem_rdata  input  16  memory read data (instruction, immediate or load data)
mem_ready  input  1  memory completes the current request this cycle
mem_req  output  1  memory request; held until mem_ready
mem_we  output  1  write qualifier for mem_req
addr_sel  output  2  address source: 0=PC (reg out), 1=src reg, 2=dst reg
src_sel  output  3  register file source select (ir[8:6])
dst_sel  output  3  register file destination select (ir[11:9])
reg_in_en  output  1  register file write strobe, one cycle
reg_out_en  output  1  register file PC drive onto address bus
pc_inc  output  1  PC increment strobe, one cycle
wb_sel  output  2  write-data mux: 0=mem_rdata, 1=ALU, 2=src reg
alu_op  output  3  ALU function (ir[2:0])
ir  output  16  current instruction register
halted  output  1  sequencer in HALT
illegal  output  1  sticky: undefined opcode executed
bus_err  output  1  sticky: memory timeout

Behaviour:
- Instruction: [15:12] opcode, [11:9] dst, [8:6] src, [2:0] funct. Opcodes: 0 NOP, 1 MOV dst<=src, 2 LDI dst<=next word, 3 LD dst<=mem[src], 4 ST mem[dst]<=src, 5 ALU dst<=dst op(funct) src, HALT_OPC halt; any other is illegal: set illegal, execute as NOP.
- Reset: state=FETCH; ir=0; all strobes, mem_req, mem_we=0; addr_sel=0, wb_sel=0, alu_op=0; halted, illegal, bus_err=0; timeout counter=0. Reset mid-transaction drops mem_req immediately.
- FETCH: mem_req=1, addr_sel=0, reg_out_en=1. On mem_ready: ir<=mem_rdata, pc_inc=1 for that cycle, next=DECODE.
- DECODE (1 cycle): src_sel/dst_sel/alu_op are driven from ir; branch by opcode: NOP/illegal->FETCH; MOV/ALU->EXEC; LDI->IMM; LD/ST->MEM; HALT->HALT.
- EXEC (1 cycle): reg_in_en=1, wb_sel=2 (MOV) or 1 (ALU); next FETCH.
- IMM: mem_req=1, addr_sel=0, reg_out_en=1; on mem_ready: reg_in_en=1, wb_sel=0, pc_inc=1; next FETCH.
- MEM: mem_req=1; LD: addr_sel=1, mem_we=0, on mem_ready reg_in_en=1, wb_sel=0; ST: addr_sel=2, mem_we=1, no reg write. Next FETCH.
- HALT: all strobes 0, halted=1; exits only by reset.
- Strobes are registered-state decodes; they are asserted in exactly the mem_ready cycle, never before.
- Minimum cycles per instruction with zero-wait memory: NOP 2, MOV/ALU 3, LD/ST 3, LDI 3.
- Timeout: counter clears on entry to any wait state and increments each cycle mem_req=1 and mem_ready=0. When it reaches TIMEOUT: drop mem_req, set bus_err, go HALT with no strobe. mem_ready on the same cycle as expiry wins: the transaction completes.
- mem_ready outside a wait state is ignored.

Optional Feature:
SINGLE_STEP_EN: adds input step (1 bit) and output paused (1 bit). After each completed instruction (non-HALT), enter PAUSE (paused=1, strobes 0) instead of FETCH; a step=1 sample advances to FETCH the next cycle. Reset puts the sequencer in PAUSE. Without the macro: no port, no PAUSE state, execution runs continuously.

Test Plan:
- Reset, memory returns 16'h1280 (MOV r1<=r2) with zero wait -> FETCH/DECODE/EXEC; reg_in_en high one cycle with dst_sel=1, src_sel=2, wb_sel=2; pc_inc exactly one pulse.
- LDI r3 (16'h2600) then data 16'd20 -> two pc_inc pulses; reg_in_en with dst_sel=3, wb_sel=0 in the immediate's mem_ready cycle.
- ST mem[r2]<=r1 (16'h4440) with mem_ready delayed 3 cycles -> mem_req, mem_we held 4 cycles, addr_sel=2, no reg_in_en.
- Opcode 4'h7 -> illegal=1 sticky, next fetch proceeds; then 16'hF000 -> halted=1, mem_req stays 0 thereafter.
- mem_ready never asserts with TIMEOUT=4 -> mem_req drops after 4 wait cycles, bus_err=1, halted=1; assert rst mid-wait -> all outputs return to reset values immediately.
- SINGLE_STEP_EN build: after reset paused=1; one step pulse runs exactly one MOV, then paused=1 again.
